seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Reads a multiplexed, active-low 7-segment display bus: segment lines plus active-low digit selects.
- Recovers the 4-bit hex value shown on each digit position. It is the reader for the team's hex-to-7-segment encoder.
- Used for display loopback checking and for sniffing external display drivers.
- Samples on a prescaled tick, requires a stable pattern before accepting it, and flags illegal patterns.

Parameters:
- NUM_DIGITS, 4, number of digit select lines and captured nibbles (1..8).
- SAMPLE_DIV, 16, clk cycles between sample ticks (>=2).
- STABLE_CNT, 3, consecutive identical samples required to accept a pattern (2..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- seg_n  in  7  segment lines, active-low, bit0=a .. bit6=g
- dig_sel_n  in  NUM_DIGITS  digit enables, active-low, one-hot when valid
- value  out  4*NUM_DIGITS  captured nibbles, digit k at [4k+3:4k]
- digit_valid  out  NUM_DIGITS  digit k holds a legally decoded nibble
- update  out  1  one-cycle pulse when any nibble is written
- err_pattern  out  1  one-cycle pulse when a stable pattern is illegal
- err_select  out  1  sticky; set when dig_sel_n is multi-hot at a tick; cleared only by reset

Behaviour:
- Reset, asynchronous on rst_n low: value=0, digit_valid=0, update=0, err_pattern=0, err_select=0, prescaler=0, FSM=IDLE.
- Reset asserted mid-capture discards all state with no pulse.
- Input synchronizer: seg_n and dig_sel_n each pass through a 2-flop synchronizer before any use.
- Prescaler:
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - tick is asserted in the cycle the count equals SAMPLE_DIV-1.
  - All FSM activity happens only on tick.
- Sample at a tick: the synchronized {digit index, seg} pair. Selects are classified as none (all ones), one-hot, or multi-hot.
- FSM states:
  - IDLE:
    - On a one-hot tick: latch the sample, run=1, go to TRACK.
    - Multi-hot: set err_select, stay in IDLE.
  - TRACK:
    - Same sample as the latch: run+1.
    - When run reaches STABLE_CNT: decode and go to LOCKED.
    - Different one-hot sample: relatch, run=1.
    - None or multi-hot: go to IDLE. Multi-hot also sets err_select.
  - LOCKED:
    - Same sample: stay, no action.
    - Different one-hot sample: relatch, run=1, go to TRACK.
    - None or multi-hot: go to IDLE as in TRACK.
- Decode, on entry to LOCKED:
  - Legal pattern: write the nibble to value[k], set digit_valid[k], pulse update in the next cycle.
  - Illegal pattern: value[k] unchanged, clear digit_valid[k], pulse err_pattern in the next cycle.
- A rewrite of the same nibble still pulses update.
- run is 4 bits and saturates at STABLE_CNT.
- Legal table, seg_n as hex {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Any other code is illegal, including 7F (blank).
- Latency from a stable bus to update: 2 sync cycles + at most STABLE_CNT*SAMPLE_DIV cycles + 1.
- Digits are rescanned independently. Other digits' values persist while digit k is tracked.

Optional Feature:
- Macro SEG_DP_EN.
- Defined:
  - Adds input seg_dp_n (1 bit, active-low) and output dp (NUM_DIGITS bits).
  - seg_dp_n is synchronized and included in the stability comparison.
  - On a legal decode, dp[k] = ~seg_dp_n. dp resets to 0.
- Undefined: no dp ports; the decimal point is ignored entirely.

Decomposition:
- Package seg_pkg holds:
  - the 16-entry active-low pattern constant array;
  - the FSM state enum (IDLE, TRACK, LOCKED);
  - SEG_BLANK = 7'h7F.
- Sub-module seg_pattern_decode: combinational, seg_n[6:0] -> {legal, nibble[3:0]} using the package table. It is the inverse of the existing encoder and is reusable.

Test Plan:
- Reset, then hold dig_sel_n=4'b1110, seg_n=7'h24 for 100 cycles -> one update pulse, value[3:0]=2, digit_valid=4'b0001.
- Scan digits 0..3 with codes 40, 79, 0E, 03, each held 60 cycles -> value=16'hBF10, digit_valid=4'hF, four update pulses.
- Digit 1 held at 7'h7F (blank) for 60 cycles after a valid capture -> err_pattern pulse, digit_valid[1]=0, value[7:4] unchanged.
- seg_n toggles between 0x40 and 0x79 every SAMPLE_DIV cycles on digit 0 -> no update, no err_pattern.
- dig_sel_n=4'b1100 at a tick -> err_select=1 and stays 1; no value change; a later valid scan still captures.
- rst_n low mid-TRACK, with run=2 -> all outputs 0 immediately, no pulse after release.

Source files
------------

// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants for the 7-segment scan reader: active-low glyph table,
// blank code and scan FSM state encoding.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // seg_n as {g,f,e,d,c,b,a}, active-low, indexed by hex digit 0..F
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } seg_state_e;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational inverse of the hex-to-7-segment encoder: maps an active-low
// segment pattern to its nibble and flags patterns outside the glyph table.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic       legal,
  output logic [3:0] nibble
);

  // Table entries are unique, so OR-accumulating the matching index is exact.
  always_comb begin
    legal  = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      legal  = legal | (seg_n == SEG_TABLE[i]);
      nibble = nibble | ((seg_n == SEG_TABLE[i]) ? 4'(i) : 4'h0);
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Multiplexed active-low 7-segment bus reader: recovers the nibble shown on
// each digit. Define SEG_DP_EN to also capture the decimal point per digit.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SAMPLE_DIV = 16,
  parameter int STABLE_CNT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_sel_n,
`ifdef SEG_DP_EN
  input  logic                    seg_dp_n,
  output logic [NUM_DIGITS-1:0]   dp,
`endif
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    update,
  output logic                    err_pattern,
  output logic                    err_select
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
`ifdef SEG_DP_EN
  localparam int SW = 8;
`else
  localparam int SW = 7;
`endif

  logic [SW-1:0]           smp_in_s;
  logic [SW-1:0]           smp_s1_q, smp_s2_q;
  logic [NUM_DIGITS-1:0]   sel_s1_q, sel_s2_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    tick_s;
  logic [NUM_DIGITS-1:0]   sel_act_s;
  logic                    sel_none_s, sel_one_s, sel_multi_s, same_s;
  logic [IW-1:0]           sel_idx_s;
  logic                    dec_legal_s;
  logic [3:0]              dec_nibble_s;
  logic [3:0]              run_inc_s;

  seg_state_e              state_q, state_d;
  logic [3:0]              run_q, run_d;
  logic [NUM_DIGITS-1:0]   lat_sel_q, lat_sel_d;
  logic [SW-1:0]           lat_smp_q, lat_smp_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic                    update_q, update_d;
  logic                    err_pattern_q, err_pattern_d;
  logic                    err_select_q, err_select_d;
`ifdef SEG_DP_EN
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;

  assign smp_in_s = {seg_dp_n, seg_n};
  assign dp       = dp_q;
`else
  assign smp_in_s = seg_n;
`endif

  seg_pattern_decode u_decode (
    .seg_n  (smp_s2_q[6:0]),
    .legal  (dec_legal_s),
    .nibble (dec_nibble_s)
  );

  // Prescaler next count and sample tick.
  always_comb begin
    tick_s = (cnt_q == CW'(SAMPLE_DIV - 1));
    if (tick_s) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Classify the synchronized select lines and compare against the latch.
  always_comb begin
    sel_act_s   = ~sel_s2_q;
    sel_none_s  = (sel_act_s == {NUM_DIGITS{1'b0}});
    sel_one_s   = $onehot(sel_act_s);
    sel_multi_s = !sel_none_s && !sel_one_s;
    same_s      = sel_one_s && (sel_s2_q == lat_sel_q) && (smp_s2_q == lat_smp_q);
    sel_idx_s   = {IW{1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sel_idx_s = sel_idx_s | (sel_act_s[i] ? IW'(i) : {IW{1'b0}});
    end
  end

  // Scan FSM: latch, count stable ticks, decode on entry to LOCKED.
  always_comb begin
    state_d       = state_q;
    run_d         = run_q;
    lat_sel_d     = lat_sel_q;
    lat_smp_d     = lat_smp_q;
    value_d       = value_q;
    valid_d       = valid_q;
    update_d      = 1'b0;
    err_pattern_d = 1'b0;
    err_select_d  = err_select_q;
`ifdef SEG_DP_EN
    dp_d          = dp_q;
`endif
    run_inc_s = (run_q >= 4'(STABLE_CNT)) ? run_q : run_q + 4'd1;
    if (tick_s) begin
      if (sel_multi_s) begin
        err_select_d = 1'b1;
      end else begin
        err_select_d = err_select_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (sel_one_s) begin
            lat_sel_d = sel_s2_q;
            lat_smp_d = smp_s2_q;
            run_d     = 4'd1;
            state_d   = ST_TRACK;
          end else begin
            state_d   = ST_IDLE;
          end
        end
        ST_TRACK: begin
          if (!sel_one_s) begin
            run_d     = 4'd0;
            state_d   = ST_IDLE;
          end else if (!same_s) begin
            lat_sel_d = sel_s2_q;
            lat_smp_d = smp_s2_q;
            run_d     = 4'd1;
          end else begin
            run_d = run_inc_s;
            if (run_inc_s >= 4'(STABLE_CNT)) begin
              state_d = ST_LOCKED;
              if (dec_legal_s) begin
                value_d[4*sel_idx_s +: 4] = dec_nibble_s;
                valid_d[sel_idx_s]        = 1'b1;
                update_d                  = 1'b1;
`ifdef SEG_DP_EN
                dp_d[sel_idx_s]           = ~smp_s2_q[7];
`endif
              end else begin
                valid_d[sel_idx_s] = 1'b0;
                err_pattern_d      = 1'b1;
              end
            end else begin
              state_d = ST_TRACK;
            end
          end
        end
        ST_LOCKED: begin
          if (!sel_one_s) begin
            run_d     = 4'd0;
            state_d   = ST_IDLE;
          end else if (!same_s) begin
            lat_sel_d = sel_s2_q;
            lat_smp_d = smp_s2_q;
            run_d     = 4'd1;
            state_d   = ST_TRACK;
          end else begin
            state_d   = ST_LOCKED;
          end
        end
        default: begin
          run_d   = 4'd0;
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, synchronizer and output registers; sync stages idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_s1_q      <= {SW{1'b1}};
      smp_s2_q      <= {SW{1'b1}};
      sel_s1_q      <= {NUM_DIGITS{1'b1}};
      sel_s2_q      <= {NUM_DIGITS{1'b1}};
      cnt_q         <= {CW{1'b0}};
      state_q       <= ST_IDLE;
      run_q         <= 4'd0;
      lat_sel_q     <= {NUM_DIGITS{1'b1}};
      lat_smp_q     <= {SW{1'b1}};
      value_q       <= {(4*NUM_DIGITS){1'b0}};
      valid_q       <= {NUM_DIGITS{1'b0}};
      update_q      <= 1'b0;
      err_pattern_q <= 1'b0;
      err_select_q  <= 1'b0;
`ifdef SEG_DP_EN
      dp_q          <= {NUM_DIGITS{1'b0}};
`endif
    end else begin
      smp_s1_q      <= smp_in_s;
      smp_s2_q      <= smp_s1_q;
      sel_s1_q      <= dig_sel_n;
      sel_s2_q      <= sel_s1_q;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      run_q         <= run_d;
      lat_sel_q     <= lat_sel_d;
      lat_smp_q     <= lat_smp_d;
      value_q       <= value_d;
      valid_q       <= valid_d;
      update_q      <= update_d;
      err_pattern_q <= err_pattern_d;
      err_select_q  <= err_select_d;
`ifdef SEG_DP_EN
      dp_q          <= dp_d;
`endif
    end
  end

  assign value       = value_q;
  assign digit_valid = valid_q;
  assign update      = update_q;
  assign err_pattern = err_pattern_q;
  assign err_select  = err_select_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed scoreboard bench for seg_scan_decoder: expected update/err_pattern
// events are queued with the stimulus and checked when the pulses appear.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_n = 7'h7F;
  logic [3:0]  dig_sel_n = 4'hF;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic        update, err_pattern, err_select;
`ifdef SEG_DP_EN
  logic        seg_dp_n = 1'b1;
  logic [3:0]  dp;
`endif

  typedef struct packed {
    logic        is_err;
    logic [15:0] val;
    logic [3:0]  vld;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          vectors = 0;
  int          miscompares = 0;
  logic [3:0]  tb_cnt;
  logic        aligned;

  seg_scan_decoder #(.NUM_DIGITS(4), .SAMPLE_DIV(16), .STABLE_CNT(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .dig_sel_n   (dig_sel_n),
`ifdef SEG_DP_EN
    .seg_dp_n    (seg_dp_n),
    .dp          (dp),
`endif
    .value       (value),
    .digit_valid (digit_valid),
    .update      (update),
    .err_pattern (err_pattern),
    .err_select  (err_select)
  );

  always #5 clk = ~clk;

  // Reference prescaler phase, used only to place the mid-TRACK reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cnt <= 4'd0;
    else        tb_cnt <= (tb_cnt == 4'd15) ? 4'd0 : tb_cnt + 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [3:0] sel, input logic [6:0] seg, input int cycles);
    dig_sel_n = sel;
    seg_n     = seg;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic push(input logic is_err, input logic [15:0] val, input logic [3:0] vld);
    exp_t e;
    e.is_err = is_err;
    e.val    = val;
    e.vld    = vld;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (update || err_pattern)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, update, err_pattern}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind", {30'd0, update, err_pattern}, mon_e.is_err ? 32'd1 : 32'd2);
        check("pulse_value", {16'd0, value}, {16'd0, mon_e.val});
        check("pulse_valid", {28'd0, digit_valid}, {28'd0, mon_e.vld});
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_value", {16'd0, value}, 32'd0);
    check("rst_valid", {28'd0, digit_valid}, 32'd0);
    check("rst_update", {31'd0, update}, 32'd0);
    check("rst_err_pattern", {31'd0, err_pattern}, 32'd0);
    check("rst_err_select", {31'd0, err_select}, 32'd0);
    rst_n = 1'b1;

    // Single digit capture
    push(1'b0, 16'h0002, 4'b0001);
    hold(4'b1110, 7'h24, 100);
    check("single_drain", exp_q.size(), 32'd0);
    check("single_value", {16'd0, value}, 32'h0002);

    // Scan all four digits
    push(1'b0, 16'h0000, 4'b0001);
    push(1'b0, 16'h0010, 4'b0011);
    push(1'b0, 16'h0F10, 4'b0111);
    push(1'b0, 16'hBF10, 4'b1111);
    hold(4'b1110, 7'h40, 60);
    hold(4'b1101, 7'h79, 60);
    hold(4'b1011, 7'h0E, 60);
    hold(4'b0111, 7'h03, 60);
    check("scan_drain", exp_q.size(), 32'd0);
    check("scan_value", {16'd0, value}, 32'hBF10);
    check("scan_valid", {28'd0, digit_valid}, 32'hF);

    // Blank is illegal: value kept, valid cleared
    push(1'b1, 16'hBF10, 4'b1101);
    hold(4'b1101, 7'h7F, 60);
    check("blank_drain", exp_q.size(), 32'd0);
    check("blank_nibble", {28'd0, value[7:4]}, 32'h1);
    check("blank_valid", {28'd0, digit_valid}, 32'hD);

    // Unstable digit 0: never accepted
    for (int i = 0; i < 8; i++) hold(4'b1110, (i % 2 == 0) ? 7'h40 : 7'h79, 16);
    check("toggle_value", {16'd0, value}, 32'hBF10);
    check("toggle_valid", {28'd0, digit_valid}, 32'hD);

    // Multi-hot select is sticky
    hold(4'b1100, 7'h79, 24);
    check("multi_err_select", {31'd0, err_select}, 32'd1);
    check("multi_value", {16'd0, value}, 32'hBF10);
    hold(4'b1111, 7'h7F, 20);
    check("sticky_err_select", {31'd0, err_select}, 32'd1);

    // Later scan still captures; same nibble rewrite still pulses
    push(1'b0, 16'hBF10, 4'b1111);
    hold(4'b1101, 7'h79, 60);
    check("rescan_drain", exp_q.size(), 32'd0);
    check("rescan_valid", {28'd0, digit_valid}, 32'hF);

    // Reset two ticks into TRACK on digit 2
    aligned = 1'b0;
    for (int i = 0; i < 64 && !aligned; i++) begin
      @(posedge clk);
      #1;
      if (tb_cnt == 4'd0) aligned = 1'b1;
    end
    check("align_prescaler", {31'd0, aligned}, 32'd1);
    dig_sel_n = 4'b1011;
    seg_n     = 7'h21;
    repeat (40) @(posedge clk);
    #3;
    check("pre_reset_drain", exp_q.size(), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_value", {16'd0, value}, 32'd0);
    check("midrst_valid", {28'd0, digit_valid}, 32'd0);
    check("midrst_err_select", {31'd0, err_select}, 32'd0);
    check("midrst_pulses", {30'd0, update, err_pattern}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hold(4'b1111, 7'h7F, 60);
    check("post_reset_value", {16'd0, value}, 32'd0);
    check("post_reset_drain", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
